decode_stage: RTL and testbench

- ID stage plus ID/EX pipeline register for the RV32I core.
- Takes fetched instructions from IF and drives the register_file read address ports.
- Bypasses the same-cycle writeback value and generates immediates.
- Detects load-use hazards and inserts a bubble, then registers operands and control into EX via a valid/ready handshake.

---
 rtl/decode_stage.sv | 168 ++++++++++++++++
 tb/tb_decode_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I ID stage: register-file addressing, writeback bypass, immediate generation,
// load-use bubble insertion and the ID/EX register with a valid/ready handshake.
module decode_stage #(
  parameter int DATA_WIDTH       = 32,
  parameter bit ENABLE_WB_BYPASS = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [31:0]           if_instruction,
  input  logic [31:0]           if_pc,
  output logic                  id_ready,
  input  logic                  flush,
  output logic [4:0]            read_register_1,
  output logic [4:0]            read_register_2,
  input  logic [DATA_WIDTH-1:0] read_data_1,
  input  logic [DATA_WIDTH-1:0] read_data_2,
  input  logic                  wb_register_write,
  input  logic [4:0]            wb_write_register,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [31:0]           ex_pc,
  output logic [6:0]            ex_opcode,
  output logic [2:0]            ex_funct3,
  output logic [6:0]            ex_funct7,
  output logic [4:0]            ex_rd,
  output logic [DATA_WIDTH-1:0] ex_rs1_data,
  output logic [DATA_WIDTH-1:0] ex_rs2_data,
  output logic [DATA_WIDTH-1:0] ex_immediate,
  output logic                  ex_illegal
);

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic [31:0]           pc;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    logic                  illegal;
  } idex_t;

  logic [6:0]            opcode;
  logic [4:0]            rs1_addr, rs2_addr;
  logic                  rs1_used, rs2_used, illegal;
  logic                  rs1_hit, rs2_hit;
  logic [DATA_WIDTH-1:0] rs1_data, rs2_data;
  logic [31:0]           imm32;
  logic                  hazard, advance;
  idex_t                 decoded, idex_d, idex_q;
  logic                  valid_d, valid_q;

  assign opcode          = if_instruction[6:0];
  assign rs1_addr        = if_instruction[19:15];
  assign rs2_addr        = if_instruction[24:20];
  assign read_register_1 = rs1_addr;
  assign read_register_2 = rs2_addr;

  assign rs1_used = opcode inside {OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  assign rs2_used = opcode inside {OP_REG, OP_STORE, OP_BRANCH};
  assign illegal  = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                     OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM});

  // The writeback in flight this cycle has not reached the register file yet.
  assign rs1_hit  = ENABLE_WB_BYPASS && wb_register_write && (wb_write_register != 5'd0) &&
                    (wb_write_register == rs1_addr);
  assign rs2_hit  = ENABLE_WB_BYPASS && wb_register_write && (wb_write_register != 5'd0) &&
                    (wb_write_register == rs2_addr);
  assign rs1_data = (rs1_addr == 5'd0) ? '0 : (rs1_hit ? wb_write_data : read_data_1);
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : (rs2_hit ? wb_write_data : read_data_2);

  always_comb begin
    // NOTE: default assigned first so every path drives imm32 and no latch is inferred.
    imm32 = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        imm32 = {{20{if_instruction[31]}}, if_instruction[31:20]};
      OP_STORE:
        imm32 = {{20{if_instruction[31]}}, if_instruction[31:25], if_instruction[11:7]};
      OP_BRANCH:
        imm32 = {{19{if_instruction[31]}}, if_instruction[31], if_instruction[7],
                 if_instruction[30:25], if_instruction[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {if_instruction[31:12], 12'b0};
      OP_JAL:
        imm32 = {{11{if_instruction[31]}}, if_instruction[31], if_instruction[19:12],
                 if_instruction[20], if_instruction[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  always_comb begin
    decoded.pc       = if_pc;
    decoded.opcode   = opcode;
    decoded.funct3   = if_instruction[14:12];
    decoded.funct7   = if_instruction[31:25];
    decoded.rd       = (illegal || opcode == OP_STORE || opcode == OP_BRANCH) ? 5'd0
                                                                             : if_instruction[11:7];
    decoded.rs1_data = rs1_data;
    decoded.rs2_data = rs2_data;
    decoded.imm      = DATA_WIDTH'($signed(imm32));
    decoded.illegal  = illegal;
  end

  // A load in EX cannot forward its data in time; hold the consumer for one cycle.
  assign hazard   = valid_q && (idex_q.opcode == OP_LOAD) && (idex_q.rd != 5'd0) && if_valid &&
                    ((rs1_used && rs1_addr == idex_q.rd) || (rs2_used && rs2_addr == idex_q.rd));
  assign advance  = ex_ready || !valid_q;
  assign id_ready = flush || (advance && !hazard);

  always_comb begin
    valid_d = valid_q;
    idex_d  = idex_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (advance) begin
      if (hazard) begin
        valid_d = 1'b0;
      end else if (if_valid) begin
        valid_d = 1'b1;
        idex_d  = decoded;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      valid_q <= valid_d;
      idex_q  <= idex_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = idex_q.pc;
  assign ex_opcode    = idex_q.opcode;
  assign ex_funct3    = idex_q.funct3;
  assign ex_funct7    = idex_q.funct7;
  assign ex_rd        = idex_q.rd;
  assign ex_rs1_data  = idex_q.rs1_data;
  assign ex_rs2_data  = idex_q.rs2_data;
  assign ex_immediate = idex_q.imm;
  assign ex_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic, scored against a
// queue of expected ID/EX contents built from the RV32I decode rules.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instruction, if_pc;
  logic        id_ready, flush;
  logic [4:0]  read_register_1, read_register_2;
  logic [31:0] read_data_1, read_data_2;
  logic        wb_register_write;
  logic [4:0]  wb_write_register;
  logic [31:0] wb_write_data;
  logic        ex_ready, ex_valid;
  logic [31:0] ex_pc;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_immediate;
  logic        ex_illegal;

  decode_stage #(.DATA_WIDTH(32), .ENABLE_WB_BYPASS(1'b1)) dut (
    .clock(clock), .reset(reset), .if_valid(if_valid), .if_instruction(if_instruction),
    .if_pc(if_pc), .id_ready(id_ready), .flush(flush),
    .read_register_1(read_register_1), .read_register_2(read_register_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .wb_register_write(wb_register_write), .wb_write_register(wb_write_register),
    .wb_write_data(wb_write_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_immediate(ex_immediate),
    .ex_illegal(ex_illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] rs1, rs2, imm;
    logic        illegal;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        m_valid = 1'b0;
  logic [6:0]  m_opcode = '0;
  logic [4:0]  m_rd = '0;
  logic        accepted;
  logic        dut_ready_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic uses_rs1(input logic [6:0] op);
    return op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 || op == 7'h67;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op == 7'h33 || op == 7'h23 || op == 7'h63;
  endfunction

  function automatic logic [31:0] ref_opnd(input logic [4:0] a, input logic [31:0] d,
                                           input logic wen, input logic [4:0] wreg,
                                           input logic [31:0] wdata);
    if (a == 5'd0) return 32'd0;
    if (wen && wreg == a) return wdata;
    return d;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [6:0] op;
    logic signed [31:0] s;
    logic [31:0] sx20, sx19, sx11;
    op   = ins[6:0];
    s    = $signed(ins);
    sx20 = s >>> 20;
    sx19 = s >>> 19;
    sx11 = s >>> 11;
    e.pc      = pc;
    e.opcode  = op;
    e.funct3  = ins[14:12];
    e.funct7  = ins[31:25];
    e.illegal = !(op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h67 || op == 7'h63 ||
                  op == 7'h03 || op == 7'h23 || op == 7'h13 || op == 7'h33 || op == 7'h0F ||
                  op == 7'h73);
    e.rd      = (e.illegal || op == 7'h23 || op == 7'h63) ? 5'd0 : ins[11:7];
    e.rs1     = ref_opnd(ins[19:15], read_data_1, wb_register_write, wb_write_register, wb_write_data);
    e.rs2     = ref_opnd(ins[24:20], read_data_2, wb_register_write, wb_write_register, wb_write_data);
    case (op)
      7'h13, 7'h03, 7'h67: e.imm = sx20;
      7'h23: e.imm = (sx20 & ~32'h1F) | 32'(ins[11:7]);
      7'h63: e.imm = (sx19 & ~32'hFFF) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) |
                     (32'(ins[11:8]) << 1);
      7'h37, 7'h17: e.imm = ins & 32'hFFFFF000;
      7'h6F: e.imm = (sx11 & ~32'hFFFFF) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) |
                     (32'(ins[30:21]) << 1);
      default: e.imm = 32'd0;
    endcase
    return e;
  endfunction

  // One clock: check the combinational response mid-cycle, advance the model, step the edge.
  task automatic do_cycle();
    logic adv, haz, exp_rdy;
    @(negedge clock);
    adv = ex_ready || !m_valid;
    haz = m_valid && m_opcode == 7'h03 && m_rd != 5'd0 && if_valid &&
          ((uses_rs1(if_instruction[6:0]) && if_instruction[19:15] == m_rd) ||
           (uses_rs2(if_instruction[6:0]) && if_instruction[24:20] == m_rd));
    exp_rdy = flush || (adv && !haz);
    check("ex_valid", 32'(ex_valid), 32'(m_valid));
    check("id_ready", 32'(id_ready), 32'(exp_rdy));
    check("read_register_1", 32'(read_register_1), 32'(if_instruction[19:15]));
    check("read_register_2", 32'(read_register_2), 32'(if_instruction[24:20]));
    dut_ready_s = id_ready;
    accepted    = if_valid && exp_rdy;
    if (flush) begin
      if (m_valid && !ex_ready) void'(sb_q.pop_back());
      m_valid = 1'b0;
    end else if (adv && haz) begin
      m_valid = 1'b0;
    end else if (adv && if_valid) begin
      exp_t e;
      e = ref_decode(if_instruction, if_pc);
      sb_q.push_back(e);
      m_valid  = 1'b1;
      m_opcode = e.opcode;
      m_rd     = e.rd;
    end else if (adv) begin
      m_valid = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    if_valid       = 1'b1;
    if_instruction = ins;
    if_pc          = pc;
    do_cycle();
  endtask

  // Monitor: every handshake into EX must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && ex_valid && ex_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ex_transfer", ex_pc, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("ex_pc", ex_pc, e.pc);
          check("ex_opcode", 32'(ex_opcode), 32'(e.opcode));
          check("ex_funct3", 32'(ex_funct3), 32'(e.funct3));
          check("ex_funct7", 32'(ex_funct7), 32'(e.funct7));
          check("ex_rd", 32'(ex_rd), 32'(e.rd));
          check("ex_rs1_data", ex_rs1_data, e.rs1);
          check("ex_rs2_data", ex_rs2_data, e.rs2);
          check("ex_immediate", ex_immediate, e.imm);
          check("ex_illegal", 32'(ex_illegal), 32'(e.illegal));
        end
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  op;
    w = $urandom;
    case ($urandom_range(0, 12))
      0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h23;
      4: op = 7'h63;  5: op = 7'h67;  6: op = 7'h37;  7: op = 7'h17;
      8: op = 7'h6F;  9: op = 7'h73;  10: op = 7'h0F; 11: op = 7'h03;
      default: op = w[13:7];
    endcase
    w[24:20] = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    w[6:0]   = op;
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    reset = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    if_valid = 1'b1; if_instruction = 32'h00500093; if_pc = 32'h100;
    read_data_1 = 32'h55; read_data_2 = 32'h66;
    wb_register_write = 1'b0; wb_write_register = '0; wb_write_data = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_ex_rd", 32'(ex_rd), 32'd0);
    check("rst_ex_immediate", ex_immediate, 32'd0);
    check("rst_ex_rs1_data", ex_rs1_data, 32'd0);
    check("rst_ex_opcode", 32'(ex_opcode), 32'd0);
    check("rst_id_ready", 32'(id_ready), 32'd1);
    reset = 1'b1;

    drive(32'h00500093, 32'h100);
    check("addi_valid", 32'(ex_valid), 32'd1);
    check("addi_rd", 32'(ex_rd), 32'd1);
    check("addi_imm", ex_immediate, 32'd5);
    check("addi_rs1_x0", ex_rs1_data, 32'd0);

    drive(32'hFE20AE23, 32'h104);
    check("sw_imm", ex_immediate, 32'hFFFFFFFC);
    check("sw_rd", 32'(ex_rd), 32'd0);
    drive(32'hFE000EE3, 32'h108);
    check("beq_imm", ex_immediate, 32'hFFFFFFFC);
    drive(32'h123450B7, 32'h10C);
    check("lui_imm", ex_immediate, 32'h12345000);
    drive(32'hFFFFFFFF, 32'h110);
    check("illegal_flag", 32'(ex_illegal), 32'd1);
    check("illegal_rd", 32'(ex_rd), 32'd0);

    read_data_1 = 32'h11; read_data_2 = 32'h11;
    wb_register_write = 1'b1; wb_write_register = 5'd3; wb_write_data = 32'hAB;
    drive(32'h00318233, 32'h114);
    check("bypass_rs1", ex_rs1_data, 32'hAB);
    check("bypass_rs2", ex_rs2_data, 32'hAB);
    wb_write_register = 5'd0;
    drive(32'h00318233, 32'h118);
    check("no_bypass_x0_rs1", ex_rs1_data, 32'h11);
    check("no_bypass_x0_rs2", ex_rs2_data, 32'h11);
    wb_register_write = 1'b0;

    drive(32'h0000A283, 32'h200);
    drive(32'h00228333, 32'h204);
    check("loaduse_stall_ready", 32'(dut_ready_s), 32'd0);
    check("loaduse_bubble", 32'(ex_valid), 32'd0);
    drive(32'h00228333, 32'h204);
    check("loaduse_issue_ready", 32'(dut_ready_s), 32'd1);
    check("loaduse_issue_rd", 32'(ex_rd), 32'd6);
    drive(32'h0000A283, 32'h208);
    drive(32'h00238333, 32'h20C);
    check("no_hazard_ready", 32'(dut_ready_s), 32'd1);
    check("no_hazard_pc", ex_pc, 32'h20C);

    drive(32'h00500093, 32'h300);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h123450B7, 32'h304);
      check("bp_id_ready", 32'(dut_ready_s), 32'd0);
      check("bp_pc_stable", ex_pc, 32'h300);
    end
    ex_ready = 1'b1;
    drive(32'h123450B7, 32'h304);
    check("bp_release_ready", 32'(dut_ready_s), 32'd1);
    check("bp_release_pc", ex_pc, 32'h304);

    drive(32'h0000A283, 32'h400);
    flush = 1'b1;
    drive(32'h00228333, 32'h404);
    check("flush_id_ready", 32'(dut_ready_s), 32'd1);
    check("flush_ex_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0; if_valid = 1'b0;
    repeat (2) do_cycle();
    check("flush_never_issued", 32'(ex_valid), 32'd0);

    drive(32'h0000A283, 32'h500);
    ex_ready = 1'b0;
    drive(32'h00228333, 32'h504);
    #2 reset = 1'b0;
    #1;
    check("reset_mid_stall", 32'(ex_valid), 32'd0);
    m_valid = 1'b0;
    sb_q.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    ex_ready = 1'b1;
    drive(32'h00228333, 32'h504);
    check("post_reset_ready", 32'(dut_ready_s), 32'd1);
    check("post_reset_rd", 32'(ex_rd), 32'd6);

    pc = 32'h1000;
    accepted = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (!if_valid || accepted) begin
        if_valid       = ($urandom_range(0, 99) < 85);
        if_instruction = rand_instr();
        if_pc          = pc;
        pc             = pc + 32'd4;
      end
      ex_ready          = ($urandom_range(0, 3) != 0);
      flush             = ($urandom_range(0, 19) == 0);
      read_data_1       = $urandom;
      read_data_2       = $urandom;
      wb_register_write = ($urandom_range(0, 1) == 1);
      wb_write_register = 5'($urandom_range(0, 7));
      wb_write_data     = $urandom;
      do_cycle();
    end

    if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    repeat (3) do_cycle();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
